// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared sizes and the requester encoding for the register-file write-back path.
package regfile_wb_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int NREG   = 32;
    localparam int ADDR_W = $clog2(NREG);

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_e;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared when the
// write reaches the register file. Register 0 is hardwired clear.
module wb_scoreboard
    import regfile_wb_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              chk_busy1,
    output logic              chk_busy2,
    output logic              pending_any
);

    logic [NREG-1:0] pending_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_bit
            if (gi == 0) begin : g_zero
                assign pending_reg[gi] = 1'b0;
            end else begin : g_live
                logic bit_reg;
                logic set_hit;
                logic clr_hit;

                assign set_hit = set_en && (set_addr == ADDR_W'(gi));
                assign clr_hit = clr_en && (clr_addr == ADDR_W'(gi));

                // A new issue on the commit edge must survive the clear.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        bit_reg <= 1'b0;
                    end else if (set_hit) begin
                        bit_reg <= 1'b1;
                    end else if (clr_hit) begin
                        bit_reg <= 1'b0;
                    end
                end

                assign pending_reg[gi] = bit_reg;
            end
        end
    endgenerate

    assign chk_busy1   = !is_zero_reg(chk_addr1) && pending_reg[chk_addr1];
    assign chk_busy2   = !is_zero_reg(chk_addr2) && pending_reg[chk_addr2];
    assign pending_any = |pending_reg;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: round-robin arbitration of ALU and load results onto the
// register file's single write port, plus the pending-write scoreboard.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              regwrite,
    output logic [ADDR_W-1:0] adr_wr_reg,
    output logic [DATA_W-1:0] wr_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              chk_busy1,
    output logic              chk_busy2,
    output logic              pending_any
);

    req_e              last_grant_reg;
    req_e              last_grant_next;
    logic              alu_grant;
    logic              ld_grant;
    logic              win_valid;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              regwrite_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;

    // Under contention the side that did not win the previous transfer goes first.
    always_comb begin
        alu_grant       = alu_valid && (!ld_valid || last_grant_reg == REQ_LD);
        ld_grant        = ld_valid && !alu_grant;
        win_valid       = alu_grant || ld_grant;
        win_addr        = alu_grant ? alu_addr : ld_addr;
        win_data        = alu_grant ? alu_data : ld_data;
        last_grant_next = last_grant_reg;
        if (alu_grant) begin
            last_grant_next = REQ_ALU;
        end else if (ld_grant) begin
            last_grant_next = REQ_LD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_reg <= REQ_LD;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

    // Writes to x0 are accepted but never reach the file; address/data hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_reg <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
        end else begin
            regwrite_reg <= win_valid && !is_zero_reg(win_addr);
            if (win_valid && !is_zero_reg(win_addr)) begin
                wr_addr_reg <= win_addr;
                wr_data_reg <= win_data;
            end
        end
    end

    assign alu_ready  = alu_grant;
    assign ld_ready   = ld_grant;
    assign regwrite   = regwrite_reg;
    assign adr_wr_reg = wr_addr_reg;
    assign wr_data    = wr_data_reg;

    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en      (issue_valid),
        .set_addr    (issue_addr),
        .clr_en      (regwrite_reg),
        .clr_addr    (wr_addr_reg),
        .chk_addr1   (chk_addr1),
        .chk_addr2   (chk_addr2),
        .chk_busy1   (chk_busy1),
        .chk_busy2   (chk_busy2),
        .pending_any (pending_any)
    );

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: expected writes go through a queue, pending
// bits are tracked by a small model updated at each clock edge.
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        regwrite;
    logic [4:0]  adr_wr_reg;
    logic [31:0] wr_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        chk_busy1;
    logic        chk_busy2;
    logic        pending_any;

    typedef struct {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         cur;
    logic [4:0]  hold_a;
    logic [31:0] hold_d;
    logic [31:0] exp_pend;
    int          total = 0;
    int          bad = 0;
    int          step_no = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .regwrite    (regwrite),
        .adr_wr_reg  (adr_wr_reg),
        .wr_data     (wr_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .chk_addr1   (chk_addr1),
        .chk_addr2   (chk_addr2),
        .chk_busy1   (chk_busy1),
        .chk_busy2   (chk_busy2),
        .pending_any (pending_any)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // One cycle: drive at posedge+1, check combinational outputs, cross the edge,
    // then check the registered write port against the scoreboard queue.
    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [4:0] la, input logic [31:0] ldd,
                        input logic ear, input logic elr,
                        input logic iv, input logic [4:0] ia);
        wr_t e;
        alu_valid   = av;
        alu_addr    = aa;
        alu_data    = ad;
        ld_valid    = lv;
        ld_addr     = la;
        ld_data     = ldd;
        issue_valid = iv;
        issue_addr  = ia;
        #1;
        chk("alu_ready", 32'(alu_ready), 32'(ear));
        chk("ld_ready", 32'(ld_ready), 32'(elr));
        chk("chk_busy1", 32'(chk_busy1), 32'((chk_addr1 != 5'd0) && exp_pend[chk_addr1]));
        chk("chk_busy2", 32'(chk_busy2), 32'((chk_addr2 != 5'd0) && exp_pend[chk_addr2]));
        chk("pending_any", 32'(pending_any), 32'(|exp_pend));
        if (ear && aa != 5'd0) begin
            e = '{1'b1, aa, ad};
        end else if (elr && la != 5'd0) begin
            e = '{1'b1, la, ldd};
        end else begin
            e = '{1'b0, 5'd0, 32'd0};
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (cur.we) exp_pend[cur.a] = 1'b0;
        if (iv && ia != 5'd0) exp_pend[ia] = 1'b1;
        #1;
        cur = exp_q.pop_front();
        if (cur.we) begin
            hold_a = cur.a;
            hold_d = cur.d;
        end
        chk("regwrite", 32'(regwrite), 32'(cur.we));
        chk("adr_wr_reg", 32'(adr_wr_reg), 32'(hold_a));
        chk("wr_data", wr_data, hold_d);
        step_no++;
        $display("step %0d: alu_rdy=%b ld_rdy=%b -> regwrite=%b adr=%0d data=0x%08h busy1=%b busy2=%b pend_any=%b",
                 step_no, ear, elr, regwrite, adr_wr_reg, wr_data, chk_busy1, chk_busy2, pending_any);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
        ld_valid = 1'b0;  ld_addr = 5'd0;  ld_data = 32'd0;
        issue_valid = 1'b0; issue_addr = 5'd0;
        chk_addr1 = 5'd5; chk_addr2 = 5'd0;
        cur = '{1'b0, 5'd0, 32'd0};
        hold_a = 5'd0; hold_d = 32'd0; exp_pend = 32'd0;

        // Reset state
        #1 rst = 1'b0;
        #1;
        chk("rst_regwrite", 32'(regwrite), 32'd0);
        chk("rst_adr", 32'(adr_wr_reg), 32'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_pending_any", 32'(pending_any), 32'd0);
        chk("rst_busy1", 32'(chk_busy1), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ALU alone: x5 = 0xDEADBEEF, then write port goes idle and holds
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        idle();
        idle();

        // Load alone (last_grant -> load), then full contention for 4 cycles
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h0000_020A, 1'b0, 1'b1, 1'b0, 5'd0);
        step(1'b1, 5'd1, 32'h0000_0101, 1'b1, 5'd6, 32'h0000_0206, 1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b1, 5'd2, 32'h0000_0102, 1'b1, 5'd6, 32'h0000_0206, 1'b0, 1'b1, 1'b0, 5'd0);
        step(1'b1, 5'd2, 32'h0000_0102, 1'b1, 5'd7, 32'h0000_0207, 1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b1, 5'd3, 32'h0000_0103, 1'b1, 5'd7, 32'h0000_0207, 1'b0, 1'b1, 1'b0, 5'd0);
        idle();
        idle();

        // Issue x3, write x3 later; busy persists through the commit cycle
        chk_addr1 = 5'd3; chk_addr2 = 5'd6;
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3);
        idle();
        step(1'b1, 5'd3, 32'hC0FFEE03, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        idle();
        idle();

        // Re-issue x3 on the same edge its write commits: bit must stay set
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3);
        step(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3);
        idle();
        step(1'b1, 5'd3, 32'h0000_0044, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        idle();
        idle();

        // Load to x0 is accepted but dropped; issue to x0 never marks busy
        chk_addr1 = 5'd0;
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 1'b1, 1'b1, 5'd0);
        idle();
        idle();

        // Build pending = 0xF0 with a write in flight, then reset between edges
        chk_addr1 = 5'd4; chk_addr2 = 5'd7;
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd6);
        step(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd7);
        alu_valid = 1'b0; issue_valid = 1'b0;
        chk("pre_rst_pend", exp_pend, 32'h0000_00F0);
        chk("pre_rst_pending_any", 32'(pending_any), 32'd1);
        chk("pre_rst_busy2", 32'(chk_busy2), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_regwrite", 32'(regwrite), 32'd0);
        chk("async_rst_adr", 32'(adr_wr_reg), 32'd0);
        chk("async_rst_data", wr_data, 32'd0);
        chk("async_rst_pending_any", 32'(pending_any), 32'd0);
        chk("async_rst_busy1", 32'(chk_busy1), 32'd0);
        chk("async_rst_busy2", 32'(chk_busy2), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
